// File: rtl/writeback_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_regfile_pkg
//  Description : Shared pipeline constants and encodings for the write-back
//                stage and general-purpose register file.
//                  B        - data width in bits
//                  W        - register address width
//                  NREG     - number of architectural registers (2**W)
//                  ZERO_REG - hard-wired zero register address
//                  CNT_W    - width of the committed-write counter
//                  memtoreg_e - MemtoReg select encoding (MEM = 1, ALU = 0)
//  Revision    : 1.0 - initial release
// ============================================================================
package writeback_regfile_pkg;

  localparam int B     = 32;
  localparam int W     = 5;
  localparam int NREG  = 2 ** W;
  localparam int CNT_W = 32;

  localparam logic [W-1:0] ZERO_REG = '0;

  typedef enum logic {
    MTR_ALU = 1'b0,
    MTR_MEM = 1'b1
  } memtoreg_e;

endpackage : writeback_regfile_pkg
`default_nettype wire

// File: rtl/writeback_regfile_core.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_core
//  Description : 2**W x B register file with asynchronous clear, one write
//                port, two combinational read ports with same-cycle write
//                bypass, and a storage-only debug read port.
//  Ports       :
//    clk         in   clock, writes on rising edge
//    reset       in   asynchronous active-high clear of all registers
//    we_i        in   write enable (already qualified by the caller)
//    waddr_i     in   write address
//    wdata_i     in   write data
//    ra_addr_i   in   read port A address
//    rb_addr_i   in   read port B address
//    dbg_addr_i  in   debug read address
//    ra_data_o   out  read port A data (bypassed)
//    rb_data_o   out  read port B data (bypassed)
//    dbg_data_o  out  debug read data (committed storage only)
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_core
  import writeback_regfile_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         we_i,
  input  logic [W-1:0] waddr_i,
  input  logic [B-1:0] wdata_i,
  input  logic [W-1:0] ra_addr_i,
  input  logic [W-1:0] rb_addr_i,
  input  logic [W-1:0] dbg_addr_i,
  output logic [B-1:0] ra_data_o,
  output logic [B-1:0] rb_data_o,
  output logic [B-1:0] dbg_data_o
);

  // Flattened view of the storage; entry 0 is a constant zero, never a flop.
  logic [NREG-1:0][B-1:0] regs_w;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs_w[gi] = '0;
      end else begin : g_store
        logic [B-1:0] reg_q;

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            reg_q <= '0;
          end else if (we_i && (waddr_i == W'(gi))) begin
            reg_q <= wdata_i;
          end
        end

        assign regs_w[gi] = reg_q;
      end
    end
  endgenerate

  // Bypass is only meaningful for a real write to a non-zero register, and is
  // suppressed while reset holds the storage cleared.
  logic bypass_en_w;
  assign bypass_en_w = we_i && !reset && (waddr_i != ZERO_REG);

  always_comb begin
    ra_data_o = regs_w[ra_addr_i];
    if (ra_addr_i == ZERO_REG) begin
      ra_data_o = '0;
    end else if (bypass_en_w && (ra_addr_i == waddr_i)) begin
      ra_data_o = wdata_i;
    end
  end

  always_comb begin
    rb_data_o = regs_w[rb_addr_i];
    if (rb_addr_i == ZERO_REG) begin
      rb_data_o = '0;
    end else if (bypass_en_w && (rb_addr_i == waddr_i)) begin
      rb_data_o = wdata_i;
    end
  end

  // Entry 0 is already constant zero, so no address special-case is needed.
  assign dbg_data_o = regs_w[dbg_addr_i];

endmodule : regfile_core
`default_nettype wire

// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_regfile
//  Description : MIPS write-back stage plus general-purpose register file.
//                Selects the write-back value, qualifies the commit, counts
//                committed writes and hosts the bypassed register file.
//  Ports       :
//    clk             in   clock
//    reset           in   asynchronous active-high reset
//    read_data_in    in   MEM/WB memory read data
//    alu_result_in   in   MEM/WB ALU result
//    mux_RegDst_in   in   MEM/WB destination register
//    wb_RegWrite_in  in   MEM/WB write enable
//    wb_MemtoReg_in  in   1 = memory data, 0 = ALU result
//    rs_addr/rt_addr in   ID read port addresses
//    rs_data/rt_data out  ID read port data (with WB bypass)
//    wb_data         out  selected write-back value (EX forwarding)
//    dbg_addr        in   debug read address
//    dbg_data        out  debug read data (committed state only)
//    wb_count        out  committed writes since reset (wrapping)
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_regfile
  import writeback_regfile_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [B-1:0]     read_data_in,
  input  logic [B-1:0]     alu_result_in,
  input  logic [W-1:0]     mux_RegDst_in,
  input  logic             wb_RegWrite_in,
  input  logic             wb_MemtoReg_in,
  input  logic [W-1:0]     rs_addr,
  input  logic [W-1:0]     rt_addr,
  output logic [B-1:0]     rs_data,
  output logic [B-1:0]     rt_data,
  output logic [B-1:0]     wb_data,
  input  logic [W-1:0]     dbg_addr,
  output logic [B-1:0]     dbg_data,
  output logic [CNT_W-1:0] wb_count
);

  memtoreg_e sel_w;
  logic      commit_w;

  assign sel_w   = memtoreg_e'(wb_MemtoReg_in);
  assign wb_data = (sel_w == MTR_MEM) ? read_data_in : alu_result_in;

  // Writes to the zero register are architecturally dropped and not counted.
  assign commit_w = wb_RegWrite_in && (mux_RegDst_in != ZERO_REG);

  // Committed-write counter; wraps naturally at 2**CNT_W.
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (commit_w) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign wb_count = count_q;

  regfile_core u_regfile_core (
    .clk        (clk),
    .reset      (reset),
    .we_i       (commit_w),
    .waddr_i    (mux_RegDst_in),
    .wdata_i    (wb_data),
    .ra_addr_i  (rs_addr),
    .rb_addr_i  (rt_addr),
    .dbg_addr_i (dbg_addr),
    .ra_data_o  (rs_data),
    .rb_data_o  (rt_data),
    .dbg_data_o (dbg_data)
  );

endmodule : writeback_regfile
`default_nettype wire
